// File: rtl/decoder_proj_formal.sv
// Registered nibble decoder: 7-segment or one-hot with optional inversion.
// Tracks validity and a wrapping count of accepted loads.
module decoder_proj_formal (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] io_in,
  output logic [7:0] io_out,
  output logic       out_valid,
  output logic [7:0] load_count
);

  function automatic logic [7:0] decode(input logic [6:0] d);
    logic [6:0] seg;
    logic [7:0] r;
    case (d[3:0])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    if (d[5]) begin
      r = 8'h01 << d[2:0];
      if (d[6]) r = ~r;
    end else begin
      // Letter flag in bit 7 is never inverted
      r = {(d[3:0] >= 4'hA), (d[6] ? ~seg : seg)};
    end
    return r;
  endfunction

  logic       load;
  logic [7:0] dec;

  assign load = io_in[4];
  assign dec  = decode(io_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_out     <= 8'h00;
      out_valid  <= 1'b0;
      load_count <= 8'h00;
    end else if (load) begin
      io_out     <= dec;
      out_valid  <= 1'b1;
      load_count <= load_count + 8'd1;
    end
  end

`ifdef FORMAL
  logic       f_past;
  logic [6:0] f_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_past <= 1'b0;
      f_last <= 7'h00;
    end else begin
      f_past <= 1'b1;
      if (load) f_last <= io_in;
    end
  end

  always_comb begin
    if (!reset) begin
      if (!out_valid) assert (io_out == 8'h00 && load_count == 8'h00);
      if (out_valid) assert (io_out == decode(f_last));
      if (out_valid && f_last[5] && !f_last[6]) assert ($onehot(io_out));
    end
  end

  assert property (@(posedge clock) disable iff (reset)
    f_past && (load_count != $past(load_count)) |-> $past(load));

  cover property (@(posedge clock) disable iff (reset) load && io_in[6:5] == 2'b00);
  cover property (@(posedge clock) disable iff (reset) load && io_in[6:5] == 2'b01);
  cover property (@(posedge clock) disable iff (reset) load && io_in[6:5] == 2'b10);
  cover property (@(posedge clock) disable iff (reset) load && io_in[6:5] == 2'b11);
  cover property (@(posedge clock) disable iff (reset) load && load_count == 8'hFF);
`endif

endmodule

// File: tb/tb_decoder_proj_formal.sv
// Random and directed stimulus against a table-driven reference model.
// A queue of per-edge expectations is drained by an independent monitor.
module tb_decoder_proj_formal;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] io_in = 7'h00;
  logic [7:0] io_out;
  logic       out_valid;
  logic [7:0] load_count;

  decoder_proj_formal dut (
    .clock(clock),
    .reset(reset),
    .io_in(io_in),
    .io_out(io_out),
    .out_valid(out_valid),
    .load_count(load_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] out;
    logic       valid;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [7:0] m_out = 8'h00;
  logic       m_valid = 1'b0;
  int         m_cnt = 0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] ref_dec(input logic [6:0] d);
    int n;
    logic [7:0] r;
    n = int'(d[3:0]);
    if (d[5]) begin
      r = 8'(1 << (n % 8));
      if (d[6]) r = ~r;
    end else begin
      r[6:0] = d[6] ? ~seg_tab[n] : seg_tab[n];
      r[7] = (n >= 10);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic v,
                       input logic [7:0] c, input exp_t e);
    total++;
    if (o !== e.out || v !== e.valid || c !== e.cnt) begin
      bad++;
      $display("FAIL %s: got out=%h valid=%b cnt=%0d, want out=%h valid=%b cnt=%0d",
               tag, o, v, c, e.out, e.valid, e.cnt);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic step(input logic rst, input logic [6:0] d, input string tag);
    exp_t e;
    @(negedge clock);
    reset = rst;
    io_in = d;
    if (rst) begin
      m_out = 8'h00;
      m_valid = 1'b0;
      m_cnt = 0;
    end else if (d[4]) begin
      m_out = ref_dec(d);
      m_valid = 1'b1;
      m_cnt = (m_cnt + 1) % 256;
    end
    e.out = m_out;
    e.valid = m_valid;
    e.cnt = 8'(m_cnt);
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic async_reset(input string tag);
    exp_t z;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    z.out = 8'h00;
    z.valid = 1'b0;
    z.cnt = 8'h00;
    z.tag = tag;
    check(tag, io_out, out_valid, load_count, z);
    m_out = 8'h00;
    m_valid = 1'b0;
    m_cnt = 0;
  endtask

  always begin
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, io_out, out_valid, load_count, e);
    end
  end

  initial begin
    exp_t z;
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'h10 | 7'($urandom_range(0, 127)), "reset_hold");
    for (int i = 0; i < 20; i++)
      step(1'b0, 7'b1100011, "no_load");
    step(1'b0, 7'b0010011, "seg3");
    step(1'b0, 7'b1110101, "onehot5_inv");
    step(1'b0, 7'b1011100, "segC_inv");
    step(1'b0, 7'b0001111, "hold_after_load");
    for (int i = 0; i < 300; i++)
      step(1'b0, 7'($urandom_range(0, 127)), "random");
    async_reset("async_reset1");
    step(1'b1, 7'h1F, "reset_vs_load");
    for (int i = 0; i < 256; i++)
      step(1'b0, 7'h10 | 7'($urandom_range(0, 127)), "burst256");
    step(1'b0, 7'h00, "after_wrap");
    for (int i = 0; i < 50; i++)
      step(1'b0, 7'($urandom_range(0, 127)), "random2");
    async_reset("async_reset2");
    step(1'b0, 7'b0111010, "post_reset_first");
    step(1'b0, 7'b1100010, "post_reset_hold");
    repeat (3) @(posedge clock);
    #2;
    z.out = 8'h00;
    z.valid = 1'b0;
    z.cnt = 8'h00;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder_proj_formal.md
DECODER_PROJ_FORMAL -- requirements
Module: decoder_proj_formal

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port names follow codebase convention (clock, reset).
REQ-002 SHALL have no parameters; all widths fixed.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; clears all registers.
REQ-005 io_in  input  7  [3:0] nibble, [4] load, [5] mode (0=7-seg, 1=one-hot), [6] invert.
REQ-006 io_out  output  8  registered decoder result.
REQ-007 out_valid  output  1  high once at least one load has been captured since reset.
REQ-008 load_count  output  8  number of accepted loads since reset.

Function
REQ-009 SHALL sample io_in on every rising clock edge; an input with load=0 SHALL leave io_out, out_valid and load_count unchanged.
REQ-010 load=1 at a rising edge SHALL update io_out on that edge; latency is 1 cycle, no handshake, no back-pressure.
REQ-011 mode=0 (7-seg): io_out[6:0]={g,f,e,d,c,b,a}, encoded as follows:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
REQ-012 mode=0: io_out[7] SHALL be 1 when nibble >= 10, else 0.
REQ-013 mode=1 (one-hot): io_out SHALL be 1<<nibble[2:0]; nibble[3] SHALL be ignored.
REQ-014 invert=1 SHALL complement io_out[6:0] in mode 0 and all 8 bits in mode 1; io_out[7] in mode 0 SHALL NOT be inverted.
REQ-015 out_valid SHALL set on the first accepted load and stay set until reset.
REQ-016 load_count SHALL increment by 1 per accepted load, wrapping modulo 256 (255 -> 0).
REQ-017 out_valid SHALL remain 1 across the load_count wrap.
REQ-018 Inputs SHALL have no combinational path to any output.
REQ-019 Embedded properties, enabled when FORMAL is defined:
  - mode=1 with invert=0 result is exactly one-hot.
  - out_valid=0 implies io_out=0 and load_count=0.
  - load_count changes only on an edge with load=1.
  - io_out matches the REQ-011..014 function of the last loaded input.
REQ-020 Embedded cover goals, enabled when FORMAL is defined: each mode/invert combination loaded at least once; load_count wrap.
REQ-021 Property logic SHALL be excluded from synthesis.

Reset
REQ-022 reset=1 SHALL asynchronously force io_out=8'h00, out_valid=0, load_count=8'h00, without waiting for a clock edge.
REQ-023 Reset asserted mid-operation SHALL discard the captured result immediately.
REQ-024 While reset=1, load SHALL be ignored.
REQ-025 The first edge after reset deassertion SHALL be a normal sampling edge.
REQ-026 Reset asserted on the same edge as load=1 SHALL win.

Verification
REQ-027 Reset, then io_in=7'b0010011 (nibble 3, load, 7-seg, no invert) -> next cycle io_out=8'h4F, out_valid=1, load_count=1.
REQ-028 io_in=7'b1110101 (nibble 5, load, one-hot, invert) -> io_out=8'hDF.
REQ-029 io_in=7'b1011100 (nibble C, load, 7-seg, invert) -> io_out=8'hC6: bit7=1 not inverted, [6:0]=~39.
REQ-030 io_in=7'b1100011 (load=0) held for many cycles after reset -> io_out=00, out_valid=0, load_count=0 throughout.
REQ-031 256 consecutive loads -> load_count wraps to 0 while out_valid stays 1.
REQ-032 Assert reset asynchronously between edges after loads -> all outputs 0 before the next edge.
